// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder that processes CHUNK bits per clock.
// Operands are captured in IDLE, added one chunk per cycle in RUN, and the
// registered result is presented in DONE until the consumer takes it.
// Optional feature: define CHUNKED_ADDER_SUB_EN to add a 'sub' port that
// selects a - b - cin (cout = no borrow) instead of a + b + cin.
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Effective operand B and carry-in: subtraction is a + ~b + ~cin.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_sum_d;
    logic             msb_carry_in;

    // Select operand polarity for the captured B and carry.
    always_comb begin
`ifdef CHUNKED_ADDER_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? ~cin : cin;
`else
        b_eff   = b;
        cin_eff = cin;
`endif
    end

    // Add the current chunk plus stored carry; also recover the carry into
    // the chunk's top bit, which on the last chunk is the carry into bit WIDTH-1.
    always_comb begin
        chunk_a      = a_q[k_q*CHUNK +: CHUNK];
        chunk_b      = b_q[k_q*CHUNK +: CHUNK];
        chunk_sum_d  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        msb_carry_in = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_sum_d[CHUNK-1];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[k_q*CHUNK +: CHUNK] <= chunk_sum_d[CHUNK-1:0];
                    carry_q                   <= chunk_sum_d[CHUNK];
                    if (k_q == KLAST) begin
                        cout_q  <= chunk_sum_d[CHUNK];
                        ovf_q   <= msb_carry_in ^ chunk_sum_d[CHUNK];
                        k_q     <= '0;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port sum  output  WIDTH  result, registered.
REQ-013 SHALL have port cout  output  1  carry-out of bit WIDTH-1, registered.
REQ-014 SHALL have port ovf  output  1  two's-complement overflow, registered.

Function
REQ-015 SHALL implement FSM with states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on in_valid && in_ready at a rising edge, SHALL capture a, b, cin, clear chunk index k to 0, go to RUN; otherwise stay in IDLE.
REQ-017 RUN: each cycle SHALL add chunk k of A, B and the stored carry, write CHUNK result bits into sum[k*CHUNK +: CHUNK], store the chunk carry-out, increment k.
REQ-018 RUN: after chunk NCHUNK-1 is written, SHALL go to DONE; cout = final carry; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-019 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accepting edge.
REQ-020 DONE: sum, cout, ovf SHALL hold stable while out_ready = 0; on out_ready = 1 at an edge SHALL go to IDLE.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; all WIDTH result bits SHALL be valid, with no truncation between chunks.
REQ-022 Operands presented outside IDLE SHALL be ignored and SHALL not corrupt the captured operands.
REQ-023 Results SHALL not overlap: in_ready SHALL stay low from acceptance until the DONE->IDLE transition; the earliest next accept is the cycle after the result handshake.
REQ-024 With NCHUNK = 1 (CHUNK = WIDTH), RUN SHALL last one cycle.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, k = 0, sum = 0, cout = 0, ovf = 0, out_valid = 0, internal carry = 0.
REQ-026 Reset asserted during RUN or DONE SHALL discard the operation; after release in_ready = 1 with no spurious out_valid.

Configuration
REQ-027 Macro CHUNKED_ADDER_SUB_EN defined: SHALL add port sub  input  1, captured with operands; sub = 1 SHALL compute a - b - cin (B and cin inverted internally), cout = 1 when no borrow, and ovf = signed subtraction overflow; sub = 0 SHALL behave as addition.
REQ-028 Macro CHUNKED_ADDER_SUB_EN undefined: SHALL have no sub port and SHALL only add.

Verification (WIDTH=8, CHUNK=4)
REQ-029 Reset: rst_n low, then high -> sum=0x00, cout=0, ovf=0, out_valid=0, in_ready=1.
REQ-030 a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, ovf=0; out_valid exactly 2 cycles after accept (inter-chunk carry).
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-032 Backpressure: out_ready=0 for 5 cycles with new in_valid pulses -> out_valid, sum, cout, ovf held, in_ready=0, pulses ignored; out_ready=1 -> IDLE the next cycle.
REQ-033 Reset mid-RUN: assert rst_n low one cycle after accept -> outputs cleared immediately; no out_valid after release; next operands a=0x03, b=0x04 -> sum=0x07.
REQ-034 With CHUNKED_ADDER_SUB_EN: sub=1, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
